// File: rtl/mem_access_sequencer_pkg.sv
// Shared LC-3b types for the memory-stage sequencer.
// Contents: 16-bit word type, opcode encoding, the sequencer state enum,
// the mem_ack_counter constants and a byte-opcode helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'ha,
    OP_STI  = 4'hb,
    OP_JMP  = 4'hc,
    OP_SHF  = 4'hd,
    OP_LEA  = 4'he,
    OP_TRAP = 4'hf
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS1 = 2'd1,
    ACCESS2 = 2'd2,
    DONE    = 2'd3
  } lc3b_memseq_state;

  localparam logic [1:0] MEMCNT_NONE     = 2'd0;
  localparam logic [1:0] MEMCNT_SINGLE   = 2'd1;
  localparam logic [1:0] MEMCNT_INDIRECT = 2'd2;

  function automatic logic is_byte_op(input lc3b_opcode op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_align.sv
// byte_lane_align: combinational byte-lane steering for data memory.
// Ports:
//   byte_op      in   1   access is a byte access (LDB/STB)
//   addr_lsb     in   1   bit 0 of the byte address
//   store_data   in  16   register value to store
//   rdata        in  16   raw read data from memory
//   byte_enable  out  2   lane enables (bit 1 = high byte)
//   wdata        out 16   write data, low byte replicated for byte stores
//   load_value   out 16   load result, selected byte zero-extended
module byte_lane_align
  import lc3b_types::*;
(
  input  logic       byte_op,
  input  logic       addr_lsb,
  input  lc3b_word   store_data,
  input  lc3b_word   rdata,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   load_value
);

  always_comb begin
    byte_enable = 2'b11;
    wdata       = store_data;
    load_value  = rdata;
    if (byte_op) begin
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
      // Replicating the byte lets memory pick whichever lane is enabled.
      wdata       = {store_data[7:0], store_data[7:0]};
      load_value  = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: LC-3b MEM-stage sequencer driving the data-memory port.
// Issues one access (LDR/STR/LDB/STB) or two (LDI/STI: pointer then data)
// and holds the pipeline with stall until the sequence finishes.
// Ports:
//   clk, reset (async, active-high)
//   start, opcode, mem_ack_counter, addr, store_data   from EX/MEM register
//   dmem_address/read/write/wdata/byte_enable         request to memory
//   dmem_resp, dmem_rdata                              response from memory
//   load_data                                          load result
//   stall, done                                        pipeline control
module mem_access_sequencer
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  lc3b_opcode opcode,
  input  logic [1:0] mem_ack_counter,
  input  lc3b_word   addr,
  input  lc3b_word   store_data,
  output lc3b_word   dmem_address,
  output logic       dmem_read,
  output logic       dmem_write,
  output lc3b_word   dmem_wdata,
  output logic [1:0] dmem_byte_enable,
  input  logic       dmem_resp,
  input  lc3b_word   dmem_rdata,
  output lc3b_word   load_data,
  output logic       stall,
  output logic       done
);

  lc3b_memseq_state state_reg, state_next;
  lc3b_opcode       op_reg;
  lc3b_word         addr_reg;
  lc3b_word         sdata_reg;
  logic [1:0]       cnt_reg;
  lc3b_word         ptr_reg;
  lc3b_word         load_reg;

  logic       accept;
  logic       capture;
  logic       lane_byte;
  logic [1:0] lane_be;
  lc3b_word   lane_wdata;
  lc3b_word   lane_load;

  assign accept = (state_reg == IDLE) && start &&
                  ((mem_ack_counter == MEMCNT_SINGLE) ||
                   (mem_ack_counter == MEMCNT_INDIRECT));

  // The second access of an indirect op is always a full word.
  assign lane_byte = (state_reg == ACCESS1) && is_byte_op(op_reg);

  byte_lane_align u_align (
    .byte_op     (lane_byte),
    .addr_lsb    (addr_reg[0]),
    .store_data  (sdata_reg),
    .rdata       (dmem_rdata),
    .byte_enable (lane_be),
    .wdata       (lane_wdata),
    .load_value  (lane_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_BR;
      addr_reg  <= '0;
      sdata_reg <= '0;
      cnt_reg   <= MEMCNT_NONE;
      ptr_reg   <= '0;
      load_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg    <= opcode;
        addr_reg  <= addr;
        sdata_reg <= store_data;
        cnt_reg   <= mem_ack_counter;
      end
      if ((state_reg == ACCESS1) && dmem_resp && (cnt_reg == MEMCNT_INDIRECT))
        ptr_reg <= {dmem_rdata[15:1], 1'b0};
      if (capture)
        load_reg <= lane_load;
    end
  end

  always_comb begin
    state_next       = state_reg;
    dmem_address     = '0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    stall            = 1'b0;
    done             = 1'b0;
    capture          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = ACCESS1;
        end
      end
      ACCESS1: begin
        stall            = 1'b1;
        dmem_write       = (op_reg == OP_STR) || (op_reg == OP_STB);
        dmem_read        = !dmem_write;
        dmem_address     = lane_byte ? addr_reg : {addr_reg[15:1], 1'b0};
        dmem_byte_enable = lane_be;
        dmem_wdata       = dmem_write ? lane_wdata : '0;
        if (dmem_resp) begin
          if (cnt_reg == MEMCNT_INDIRECT) begin
            state_next = ACCESS2;
          end else begin
            capture    = dmem_read;
            state_next = DONE;
          end
        end
      end
      ACCESS2: begin
        stall            = 1'b1;
        dmem_write       = (op_reg == OP_STI);
        dmem_read        = !dmem_write;
        dmem_address     = ptr_reg;
        dmem_byte_enable = lane_be;
        dmem_wdata       = dmem_write ? lane_wdata : '0;
        if (dmem_resp) begin
          capture    = dmem_read;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_data = load_reg;

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  lc3b_opcode opcode;
  logic [1:0] mem_ack_counter;
  lc3b_word   addr, store_data;
  lc3b_word   dmem_address, dmem_wdata, dmem_rdata, load_data;
  logic       dmem_read, dmem_write, dmem_resp, stall, done;
  logic [1:0] dmem_byte_enable;

  int tests  = 0;
  int failed = 0;
  lc3b_word model_load = 16'h0000;

  mem_access_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .opcode           (opcode),
    .mem_ack_counter  (mem_ack_counter),
    .addr             (addr),
    .store_data       (store_data),
    .dmem_address     (dmem_address),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .load_data        (load_data),
    .stall            (stall),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    lc3b_opcode op;
    logic [1:0] cnt;
    lc3b_word   addr;
    lc3b_word   sdata;
    int         w0;
    lc3b_word   r0;
    int         w1;
    lc3b_word   r1;
    int         nacc;
    lc3b_word   a1;
    logic       rd1, wr1;
    logic [1:0] be1;
    lc3b_word   wd1;
    lc3b_word   a2;
    logic       rd2, wr2;
    logic [1:0] be2;
    lc3b_word   wd2;
    lc3b_word   load;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: derive the expected accesses and result straight from the
  // opcode/count rules.
  function automatic vec_t model(input vec_t v, input lc3b_word prev);
    vec_t e;
    logic bytop;
    e = v;
    bytop  = (v.op == OP_LDB) || (v.op == OP_STB);
    e.nacc = (v.cnt == 2'd1) ? 1 : (v.cnt == 2'd2) ? 2 : 0;
    e.a1   = bytop ? v.addr : (v.addr & 16'hfffe);
    e.wr1  = (v.op == OP_STR) || (v.op == OP_STB);
    e.rd1  = !e.wr1;
    e.be1  = bytop ? (v.addr[0] ? 2'b10 : 2'b01) : 2'b11;
    e.wd1  = (v.op == OP_STB) ? {v.sdata[7:0], v.sdata[7:0]} : v.sdata;
    e.a2   = v.r0 & 16'hfffe;
    e.wr2  = (v.op == OP_STI);
    e.rd2  = !e.wr2;
    e.be2  = 2'b11;
    e.wd2  = v.sdata;
    e.load = prev;
    if (e.nacc == 1 && !e.wr1) begin
      if (v.op == OP_LDB) e.load = v.addr[0] ? (v.r0 >> 8) : (v.r0 & 16'h00ff);
      else                e.load = v.r0;
    end
    if (e.nacc == 2 && !e.wr2) e.load = v.r1;
    return e;
  endfunction

  task automatic run_vec(input vec_t e);
    int waits;
    @(posedge clk); #1;
    start = 1'b1; opcode = e.op; mem_ack_counter = e.cnt;
    addr = e.addr; store_data = e.sdata; dmem_resp = 1'b0;
    @(negedge clk);
    chk("start_stall", stall, (e.nacc > 0));
    chk("start_req", {dmem_read, dmem_write, done}, 3'b000);
    for (int k = 0; k < e.nacc; k++) begin
      waits = (k == 0) ? e.w0 : e.w1;
      for (int w = 0; w <= waits; w++) begin
        @(posedge clk); #1;
        dmem_resp  = (w == waits);
        dmem_rdata = (w == waits) ? ((k == 0) ? e.r0 : e.r1) : 16'($urandom);
        @(negedge clk);
        chk("acc_stall", {stall, done}, 2'b10);
        chk("acc_excl", dmem_read & dmem_write, 1'b0);
        chk("acc_addr", dmem_address, (k == 0) ? e.a1 : e.a2);
        chk("acc_rd", dmem_read, (k == 0) ? e.rd1 : e.rd2);
        chk("acc_wr", dmem_write, (k == 0) ? e.wr1 : e.wr2);
        chk("acc_be", dmem_byte_enable, (k == 0) ? e.be1 : e.be2);
        if (dmem_write) chk("acc_wdata", dmem_wdata, (k == 0) ? e.wd1 : e.wd2);
      end
    end
    if (e.nacc > 0) begin
      // DONE cycle: start deliberately left high to show it is ignored.
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      @(negedge clk);
      chk("done_pulse", {done, stall, dmem_read, dmem_write}, 4'b1000);
      chk("done_load", load_data, e.load);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("after_idle", {done, stall, dmem_read, dmem_write}, 4'b0000);
    chk("after_load", load_data, e.load);
    model_load = e.load;
    $display("[TB] txn op=%0d cnt=%0d addr=%h sdata=%h accesses=%0d load_data=%h",
             e.op, e.cnt, e.addr, e.sdata, e.nacc, load_data);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    reset = 1'b1; start = 1'b0; opcode = OP_BR; mem_ack_counter = 2'd0;
    addr = '0; store_data = '0; dmem_resp = 1'b0; dmem_rdata = '0;

    //        op      cnt    addr      sdata     w0 r0        w1 r1        n  a1        rd wr be     wd1       a2        rd wr be     wd2       load
    tbl[0] = '{OP_LDR, 2'd1, 16'h3005, 16'h0000, 2, 16'hbeef, 0, 16'h0000, 1, 16'h3004, 1, 0, 2'b11, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'hbeef};
    tbl[1] = '{OP_STB, 2'd1, 16'h2001, 16'h12a5, 0, 16'h0000, 0, 16'h0000, 1, 16'h2001, 0, 1, 2'b10, 16'ha5a5, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'hbeef};
    tbl[2] = '{OP_LDB, 2'd1, 16'h4001, 16'h0000, 1, 16'h9c33, 0, 16'h0000, 1, 16'h4001, 1, 0, 2'b10, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h009c};
    tbl[3] = '{OP_LDI, 2'd2, 16'h1000, 16'h0000, 0, 16'h5003, 0, 16'h7777, 2, 16'h1000, 1, 0, 2'b11, 16'h0000, 16'h5002, 1, 0, 2'b11, 16'h0000, 16'h7777};
    tbl[4] = '{OP_STI, 2'd2, 16'h1000, 16'hcafe, 0, 16'h6000, 1, 16'h0000, 2, 16'h1000, 1, 0, 2'b11, 16'h0000, 16'h6000, 0, 1, 2'b11, 16'hcafe, 16'h7777};
    tbl[5] = '{OP_ADD, 2'd0, 16'h1234, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h7777};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {dmem_read, dmem_write, stall, done}, 4'b0000);
    chk("rst_addr", dmem_address, 16'h0000);
    chk("rst_wdata", dmem_wdata, 16'h0000);
    chk("rst_be", dmem_byte_enable, 2'b00);
    chk("rst_load", load_data, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Reset asserted while the second LDI access is in flight.
    @(posedge clk); #1;
    start = 1'b1; opcode = OP_LDI; mem_ack_counter = 2'd2; addr = 16'h1000;
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = 16'h5003;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    chk("mid_acc2_addr", {dmem_read, dmem_address}, {1'b1, 16'h5002});
    #2;
    reset = 1'b1; start = 1'b0;
    #1;
    chk("mid_rst_ctrl", {dmem_read, dmem_write, stall, done}, 4'b0000);
    chk("mid_rst_load", load_data, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h4321;
    @(negedge clk);
    chk("late_resp", {dmem_read, dmem_write, stall, done}, 4'b0000);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    chk("late_resp_done", {done, stall}, 2'b00);
    chk("late_resp_load", load_data, 16'h0000);
    model_load = 16'h0000;
    $display("[TB] txn reset during ACCESS2, late resp ignored, load_data=%h", load_data);

    for (int n = 0; n < 40; n++) begin
      v = tbl[0];
      v.op    = lc3b_opcode'(4'($urandom_range(0, 15)));
      v.addr  = 16'($urandom);
      v.sdata = 16'($urandom);
      v.w0    = $urandom_range(0, 3);
      v.w1    = $urandom_range(0, 3);
      v.r0    = 16'($urandom);
      v.r1    = 16'($urandom);
      case (v.op)
        OP_LDR, OP_STR, OP_LDB, OP_STB: v.cnt = 2'd1;
        OP_LDI, OP_STI:                 v.cnt = 2'd2;
        default:                        v.cnt = 2'($urandom_range(0, 3));
      endcase
      run_vec(model(v, model_load));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
